// File: rtl/mdu_seq.sv
// Multi-cycle RV32M multiply/divide sequencer: shift-add multiplier and restoring divider.
// Define MDU_FAST_SPECIAL_EN to finish divide-by-zero and signed-overflow divides straight from IDLE.
module mdu_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       func3,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             flush,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  typedef enum logic [2:0] {IDLE, PREP, CALC, FIX, DONE} state_t;

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ONES    = {WIDTH{1'b1}};
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [2:0]       func_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             sign_a, sign_b;
  logic [WIDTH-1:0] acc;    // product high half / partial remainder
  logic [WIDTH-1:0] lo;     // multiplier / quotient
  logic [WIDTH-1:0] mcand;  // multiplicand / divisor magnitude
  logic [CNT_W-1:0] cnt;

  // Division by zero and signed overflow have architecturally fixed results.
  function automatic logic is_special(input logic [2:0] f, input logic [WIDTH-1:0] a,
                                      input logic [WIDTH-1:0] b);
    return f[2] && ((b == '0) || (!f[0] && a == MIN_NEG && b == ONES));
  endfunction

  function automatic logic [WIDTH-1:0] special_val(input logic [2:0] f,
                                                   input logic [WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] b);
    if (b == '0) return f[1] ? a : ONES;
    return f[1] ? '0 : MIN_NEG;
  endfunction

  logic             a_signed_op, b_signed_op, neg_a, neg_b;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   mul_sum, rem_sh;
  logic [WIDTH-1:0] rem_sub;
  logic             rem_ge;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0] quot_fix, rem_fix, fix_val;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    a_signed_op = (func_q == 3'b001) || (func_q == 3'b010) ||
                  (func_q == 3'b100) || (func_q == 3'b110);
    b_signed_op = (func_q == 3'b001) || (func_q == 3'b100) || (func_q == 3'b110);
    neg_a = a_signed_op && a_q[WIDTH-1];
    neg_b = b_signed_op && b_q[WIDTH-1];
    mag_a = neg_a ? -a_q : a_q;
    mag_b = neg_b ? -b_q : b_q;

    mul_sum = {1'b0, acc} + (lo[0] ? {1'b0, mcand} : '0);
    rem_sh  = {acc, lo[WIDTH-1]};
    rem_ge  = rem_sh >= {1'b0, mcand};
    rem_sub = rem_sh[WIDTH-1:0] - mcand;

    prod = {acc, lo};
    if (sign_a ^ sign_b) prod = -prod;
    quot_fix = (sign_a ^ sign_b) ? -lo : lo;
    rem_fix  = sign_a ? -acc : acc;

    if (func_q[2]) begin
      fix_val = func_q[1] ? rem_fix : quot_fix;
      if (is_special(func_q, a_q, b_q)) fix_val = special_val(func_q, a_q, b_q);
    end else begin
      fix_val = (func_q == 3'b000) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
    end
  end

  assign stall = ((state == IDLE) && start && !flush) || busy;

  // NOTE: state registers use non-blocking assignments so every branch sees pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      func_q <= '0;
      a_q    <= '0;
      b_q    <= '0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      acc    <= '0;
      lo     <= '0;
      mcand  <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      done <= 1'b0;
      if (flush && state != IDLE) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start && !flush) begin
              func_q <= func3;
              a_q    <= op_a;
              b_q    <= op_b;
`ifdef MDU_FAST_SPECIAL_EN
              if (is_special(func3, op_a, op_b)) begin
                result <= special_val(func3, op_a, op_b);
                done   <= 1'b1;
                state  <= DONE;
              end else begin
                busy  <= 1'b1;
                state <= PREP;
              end
`else
              busy  <= 1'b1;
              state <= PREP;
`endif
            end
          end
          PREP: begin
            sign_a <= neg_a;
            sign_b <= neg_b;
            lo     <= mag_a;
            mcand  <= mag_b;
            acc    <= '0;
            cnt    <= '0;
            state  <= CALC;
          end
          CALC: begin
            if (func_q[2]) begin
              acc <= rem_ge ? rem_sub : rem_sh[WIDTH-1:0];
              lo  <= {lo[WIDTH-2:0], rem_ge};
            end else begin
              acc <= mul_sum[WIDTH:1];
              lo  <= {mul_sum[0], lo[WIDTH-1:1]};
            end
            cnt <= cnt + 1'b1;
            if (cnt == LAST) state <= FIX;
          end
          FIX: begin
            result <= fix_val;
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= DONE;
          end
          DONE: state <= IDLE;
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mdu_seq.sv
// Directed bench for mdu_seq: table of ops with expected results and latency, plus flush,
// reset and start-in-DONE sequences.
module tb_mdu_seq;

  localparam int W = 32;
`ifdef MDU_FAST_SPECIAL_EN
  localparam int SPEC_LAT = 1;
`else
  localparam int SPEC_LAT = 35;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [2:0]   func3;
  logic [W-1:0] op_a, op_b;
  logic         flush;
  logic         busy, stall, done;
  logic [W-1:0] result;

  mdu_seq #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .start(start), .func3(func3), .op_a(op_a), .op_b(op_b),
    .flush(flush), .busy(busy), .stall(stall), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [2:0] f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int         lat;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Called #1 after a rising edge; returns #1 after the edge that raised done (state DONE).
  task automatic run_op(input vec_t v);
    int lat;
    logic stall_bad;
    start = 1'b1;
    func3 = v.f3;
    op_a  = v.a;
    op_b  = v.b;
    #1;
    check({v.name, "_stall_at_start"}, 32'(stall), 32'd1);
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = 1;
    stall_bad = 1'b0;
    while (!done && lat < 100) begin
      if (!stall || !busy) stall_bad = 1'b1;
      @(posedge clk);
      #1;
      lat++;
    end
    check({v.name, "_done"}, 32'(done), 32'd1);
    check({v.name, "_latency"}, 32'(lat), 32'(v.lat));
    check({v.name, "_result"}, result, v.exp);
    check({v.name, "_stall_busy_while_running"}, 32'(stall_bad), 32'd0);
    check({v.name, "_busy_in_done"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic seen_done;

    vecs.push_back('{"mul_7x-3",        3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 35});
    vecs.push_back('{"mulhu_ffxff",     3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 35});
    vecs.push_back('{"mulh_-1x-1",      3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 35});
    vecs.push_back('{"mulhsu_-1xff",    3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 35});
    vecs.push_back('{"mul_low",         3'b000, 32'h12345678, 32'h00000010, 32'h23456780, 35});
    vecs.push_back('{"mulhu_min_x2",    3'b011, 32'h80000000, 32'h00000002, 32'h00000001, 35});
    vecs.push_back('{"div_-7_2",        3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 35});
    vecs.push_back('{"rem_-7_2",        3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 35});
    vecs.push_back('{"divu_100_7",      3'b101, 32'd100,      32'd7,        32'd14,       35});
    vecs.push_back('{"remu_100_7",      3'b111, 32'd100,      32'd7,        32'd2,        35});
    vecs.push_back('{"div_7_-2",        3'b100, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 35});
    vecs.push_back('{"rem_7_-2",        3'b110, 32'd7,        32'hFFFFFFFE, 32'd1,        35});
    vecs.push_back('{"div_min_2",       3'b100, 32'h80000000, 32'd2,        32'hC0000000, 35});
    vecs.push_back('{"divu_ff_1",       3'b101, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 35});
    vecs.push_back('{"divu_5_0",        3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, SPEC_LAT});
    vecs.push_back('{"rem_5_0",         3'b110, 32'd5,        32'd0,        32'd5,        SPEC_LAT});
    vecs.push_back('{"remu_5_0",        3'b111, 32'd5,        32'd0,        32'd5,        SPEC_LAT});
    vecs.push_back('{"div_-5_0",        3'b100, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, SPEC_LAT});
    vecs.push_back('{"div_ovf",         3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, SPEC_LAT});
    vecs.push_back('{"rem_ovf",         3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, SPEC_LAT});

    reset = 1'b1;
    start = 1'b0;
    flush = 1'b0;
    func3 = '0;
    op_a  = '0;
    op_b  = '0;
    #12;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_result", result, 32'd0);
    check("reset_stall", 32'(stall), 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      run_op(vecs[i]);
      @(posedge clk);
      #1;
      check({vecs[i].name, "_done_one_cycle"}, 32'(done), 32'd0);
    end

    // start together with flush in IDLE is not accepted
    start = 1'b1;
    flush = 1'b1;
    func3 = 3'b000;
    op_a  = 32'd3;
    op_b  = 32'd4;
    #1;
    check("start_flush_stall", 32'(stall), 32'd0);
    @(posedge clk);
    #1;
    start = 1'b0;
    flush = 1'b0;
    check("start_flush_busy", 32'(busy), 32'd0);

    // flush at CALC counter 10: 12 edges after start sampling
    start = 1'b1;
    func3 = 3'b000;
    op_a  = 32'd9;
    op_b  = 32'd9;
    @(posedge clk);
    #1;
    start = 1'b0;
    seen_done = 1'b0;
    for (int i = 0; i < 11; i++) begin
      @(posedge clk);
      #1;
      if (done) seen_done = 1'b1;
    end
    check("pre_flush_busy", 32'(busy), 32'd1);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush_busy", 32'(busy), 32'd0);
    check("flush_stall", 32'(stall), 32'd0);
    check("flush_result_kept", result, 32'h00000000);
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done) seen_done = 1'b1;
    end
    check("flush_no_done", 32'(seen_done), 32'd0);
    run_op('{"after_flush_mul", 3'b000, 32'd9, 32'd9, 32'd81, 35});
    @(posedge clk);
    #1;

    // reset mid-CALC
    start = 1'b1;
    func3 = 3'b101;
    op_a  = 32'd1000;
    op_b  = 32'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
    end
    #2;
    reset = 1'b1;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_result", result, 32'd0);
    check("midrst_stall", 32'(stall), 32'd0);
    #2;
    reset = 1'b0;
    @(posedge clk);
    #1;
    seen_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done) seen_done = 1'b1;
    end
    check("midrst_no_done", 32'(seen_done), 32'd0);

    // start pulsed while in DONE is ignored
    run_op('{"divu_before_done_start", 3'b101, 32'd100, 32'd7, 32'd14, 35});
    start = 1'b1;
    func3 = 3'b000;
    op_a  = 32'd3;
    op_b  = 32'd3;
    #1;
    check("done_start_stall", 32'(stall), 32'd0);
    @(posedge clk);
    #1;
    start = 1'b0;
    check("done_start_busy", 32'(busy), 32'd0);
    seen_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done || busy) seen_done = 1'b1;
    end
    check("done_start_no_second_done", 32'(seen_done), 32'd0);
    check("done_start_result_kept", result, 32'd14);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
